// File: rtl/sort_pkg.sv
// Shared definitions for the pipelined odd-even merge sorter: stage count and
// the compare-exchange schedule, evaluated at elaboration time.
package sort_pkg;

  // One lane's role in one stage: whether it is compared, with which lane, and
  // whether it receives the element that comes first in the sort order.
  typedef struct packed {
    logic       active;
    logic       lo;
    logic [5:0] partner;
  } cmp_slot_t;

  // Number of compare stages in the network for 2^log2n lanes.
  function automatic int stages(input int log2n);
    return log2n * (log2n + 1) / 2;
  endfunction

  // Batcher odd-even merge schedule. Stages are numbered in (p, k) order:
  // p = 1, 2, 4 .. N/2 and, for each p, k = p, p/2 .. 1.
  function automatic cmp_slot_t cmp_slot(input int log2n, input int stage, input int lane);
    cmp_slot_t r;
    int n;
    int s;
    int p;
    int k;
    r = '0;
    n = 1 << log2n;
    s = 0;
    for (int pl = 0; pl < log2n; pl++) begin
      p = 1 << pl;
      for (int kl = pl; kl >= 0; kl--) begin
        k = 1 << kl;
        if (s == stage) begin
          for (int j = k % p; j < n - k; j += 2 * k) begin
            for (int i = 0; i < k; i++) begin
              // Only pairs that fall inside the same 2p-wide merge block.
              if ((i + j + k < n) && ((i + j) / (2 * p) == (i + j + k) / (2 * p))) begin
                if (lane == i + j) begin
                  r.active  = 1'b1;
                  r.lo      = 1'b1;
                  r.partner = 6'(i + j + k);
                end
                if (lane == i + j + k) begin
                  r.active  = 1'b1;
                  r.lo      = 1'b0;
                  r.partner = 6'(i + j);
                end
              end
            end
          end
        end
        s++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sort_cmp_xchg.sv
// Combinational compare-exchange on (key, idx) pairs. Keys order per desc;
// ties break on idx ascending in both modes, giving a total order.
module sort_cmp_xchg #(
  parameter int unsigned W      = 32,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned IW     = 3
) (
  input  logic [W-1:0]  a_key,
  input  logic [W-1:0]  b_key,
  input  logic [IW-1:0] a_idx,
  input  logic [IW-1:0] b_idx,
  input  logic          desc,
  output logic [W-1:0]  lo_key,
  output logic [IW-1:0] lo_idx,
  output logic [W-1:0]  hi_key,
  output logic [IW-1:0] hi_idx
);

  logic key_lt;
  logic key_eq;
  logic key_gt;
  logic a_first;

  if (SIGNED != 0) begin : gen_signed
    assign key_lt = $signed(a_key) < $signed(b_key);
  end else begin : gen_unsigned
    assign key_lt = a_key < b_key;
  end

  assign key_eq  = (a_key == b_key);
  assign key_gt  = !key_lt && !key_eq;
  assign a_first = (desc ? key_gt : key_lt) || (key_eq && (a_idx < b_idx));

  assign lo_key = a_first ? a_key : b_key;
  assign lo_idx = a_first ? a_idx : b_idx;
  assign hi_key = a_first ? b_key : a_key;
  assign hi_idx = a_first ? b_idx : a_idx;

endmodule

// File: rtl/sort_net_pipe.sv
// Fully pipelined odd-even merge sorter with valid/ready flow control,
// per-vector sort direction and source-lane tags (argsort). One register
// bank per compare stage; a single advance enable moves the whole pipe.
module sort_net_pipe
  import sort_pkg::*;
#(
  parameter int unsigned LOG2N  = 3,
  parameter int unsigned W      = 32,
  parameter int unsigned SIGNED = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_desc,
  input  logic [(1 << LOG2N)*W-1:0]     in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(1 << LOG2N)*W-1:0]     out_data,
  output logic [(1 << LOG2N)*LOG2N-1:0] out_idx
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned S  = stages(LOG2N);
  localparam int unsigned IW = LOG2N;

  // st_* [s] is the input of stage s; st_* [S] mirrors the output bank.
  logic [W-1:0]  st_key  [S+1][N];
  logic [IW-1:0] st_idx  [S+1][N];
  logic          st_desc [S+1];
  logic          st_valid[S+1];

  logic [W-1:0]  nxt_key [S][N];
  logic [IW-1:0] nxt_idx [S][N];

  logic [W-1:0]  key_q   [S][N];
  logic [IW-1:0] idx_q   [S][N];
  logic          desc_q  [S];
  logic          valid_q [S];

  logic adv;

  // Bubbles are not squeezed out, so the pipe only stops when the head is stuck.
  assign adv       = !valid_q[S-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[S-1];

  assign st_valid[0] = in_valid;
  assign st_desc[0]  = in_desc;

  for (genvar l = 0; l < N; l++) begin : gen_lane_in
    assign st_key[0][l] = in_data[l*W +: W];
    assign st_idx[0][l] = IW'(l);
  end

  for (genvar s = 0; s < S; s++) begin : gen_stage
    assign st_valid[s+1] = valid_q[s];
    assign st_desc[s+1]  = desc_q[s];

    for (genvar l = 0; l < N; l++) begin : gen_lane
      localparam cmp_slot_t Slot = cmp_slot(LOG2N, s, l);

      assign st_key[s+1][l] = key_q[s][l];
      assign st_idx[s+1][l] = idx_q[s][l];

      if (!Slot.active) begin : gen_pass
        assign nxt_key[s][l] = st_key[s][l];
        assign nxt_idx[s][l] = st_idx[s][l];
      end else if (Slot.lo) begin : gen_cmp
        localparam int unsigned P = 32'(Slot.partner);
        // The lower lane of each pair owns the comparator and drives both lanes.
        sort_cmp_xchg #(
          .W      (W),
          .SIGNED (SIGNED),
          .IW     (IW)
        ) u_cmp (
          .a_key  (st_key[s][l]),
          .b_key  (st_key[s][P]),
          .a_idx  (st_idx[s][l]),
          .b_idx  (st_idx[s][P]),
          .desc   (st_desc[s]),
          .lo_key (nxt_key[s][l]),
          .lo_idx (nxt_idx[s][l]),
          .hi_key (nxt_key[s][P]),
          .hi_idx (nxt_idx[s][P])
        );
      end
    end
  end

  // Stage registers: clear on reset, shift together on adv, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < S; s++) begin
        valid_q[s] <= 1'b0;
        desc_q[s]  <= 1'b0;
        for (int unsigned l = 0; l < N; l++) begin
          key_q[s][l] <= '0;
          idx_q[s][l] <= '0;
        end
      end
    end else if (adv) begin
      for (int unsigned s = 0; s < S; s++) begin
        valid_q[s] <= st_valid[s];
        desc_q[s]  <= st_desc[s];
        for (int unsigned l = 0; l < N; l++) begin
          key_q[s][l] <= nxt_key[s][l];
          idx_q[s][l] <= nxt_idx[s][l];
        end
      end
    end
  end

  // Flatten the last bank onto the output buses.
  always_comb begin
    out_data = '0;
    out_idx  = '0;
    for (int unsigned l = 0; l < N; l++) begin
      out_data[l*W +: W]   = key_q[S-1][l];
      out_idx[l*IW +: IW]  = idx_q[S-1][l];
    end
  end

endmodule

// File: tb/tb_sort_net_pipe.sv
// Scoreboard bench: four sorter instances (N=8 unsigned, N=8 signed sharing
// the same stimulus, N=2, N=32). Expected vectors come from a plain
// sort-by-(key, lane) reference model and are checked as outputs handshake.
module tb_sort_net_pipe;

  typedef struct {
    logic [255:0] data;
    logic [159:0] idx;
    bit           chk_idx;
    int           acc;
    int           st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Group ab: u_a (unsigned) and u_b (signed) see identical inputs.
  logic        ab_iv = 1'b0, ab_desc = 1'b0, ab_ordy = 1'b1;
  logic [63:0] ab_idat = '0;
  logic        a_irdy, a_ov, b_irdy, b_ov;
  logic [63:0] a_od, b_od;
  logic [23:0] a_oi, b_oi;

  logic        c_iv = 1'b0, c_desc = 1'b0, c_ordy = 1'b1;
  logic [15:0] c_idat = '0;
  logic        c_irdy, c_ov;
  logic [15:0] c_od;
  logic [1:0]  c_oi;

  logic         d_iv = 1'b0, d_desc = 1'b0, d_ordy = 1'b1;
  logic [255:0] d_idat = '0;
  logic         d_irdy, d_ov;
  logic [255:0] d_od;
  logic [159:0] d_oi;

  int checks = 0;
  int errors = 0;

  exp_t pend[4][$];
  exp_t fly[4][$];
  exp_t ovr_e[4];
  bit   ovr_on[4];
  int   stall[4];
  int   cyc = 0;
  int   lat_s[4] = '{6, 6, 1, 15};

  logic         mv[4], mrdy[4], mov[4], mordy[4];
  logic [255:0] mod[4];
  logic [159:0] moi[4];

  sort_net_pipe #(.LOG2N(3), .W(8), .SIGNED(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(ab_iv), .in_ready(a_irdy), .in_desc(ab_desc),
    .in_data(ab_idat), .out_valid(a_ov), .out_ready(ab_ordy), .out_data(a_od), .out_idx(a_oi)
  );
  sort_net_pipe #(.LOG2N(3), .W(8), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(ab_iv), .in_ready(b_irdy), .in_desc(ab_desc),
    .in_data(ab_idat), .out_valid(b_ov), .out_ready(ab_ordy), .out_data(b_od), .out_idx(b_oi)
  );
  sort_net_pipe #(.LOG2N(1), .W(8), .SIGNED(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_irdy), .in_desc(c_desc),
    .in_data(c_idat), .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_od), .out_idx(c_oi)
  );
  sort_net_pipe #(.LOG2N(5), .W(8), .SIGNED(0)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_irdy), .in_desc(d_desc),
    .in_data(d_idat), .out_valid(d_ov), .out_ready(d_ordy), .out_data(d_od), .out_idx(d_oi)
  );

  always #5 clk = ~clk;

  always_comb begin
    mv[0] = ab_iv;   mv[1] = ab_iv;   mv[2] = c_iv;   mv[3] = d_iv;
    mrdy[0] = a_irdy; mrdy[1] = b_irdy; mrdy[2] = c_irdy; mrdy[3] = d_irdy;
    mov[0] = a_ov;   mov[1] = b_ov;   mov[2] = c_ov;   mov[3] = d_ov;
    mordy[0] = ab_ordy; mordy[1] = ab_ordy; mordy[2] = c_ordy; mordy[3] = d_ordy;
    mod[0] = {192'b0, a_od}; mod[1] = {192'b0, b_od}; mod[2] = {240'b0, c_od}; mod[3] = d_od;
    moi[0] = {136'b0, a_oi}; moi[1] = {136'b0, b_oi}; moi[2] = {158'b0, c_oi}; moi[3] = d_oi;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference: order lanes by key (per mode/signedness), ties by lane number.
  function automatic exp_t model(input logic [255:0] data, input bit desc, input int log2n,
                                 input bit sgn);
    exp_t e;
    int   key[32];
    int   ord[32];
    int   n, cur, j, tmp;
    logic [7:0] v;
    e.data = '0; e.idx = '0; e.chk_idx = 1'b1; e.acc = 0; e.st = 0;
    n = 1 << log2n;
    for (int i = 0; i < n; i++) begin
      v = data[i*8 +: 8];
      key[i] = sgn ? int'($signed(v)) : int'(v);
      ord[i] = i;
    end
    for (int i = 1; i < n; i++) begin
      cur = ord[i];
      j = i - 1;
      while (j >= 0 && ((desc ? key[cur] > key[ord[j]] : key[cur] < key[ord[j]]) ||
                        (key[cur] == key[ord[j]] && cur < ord[j]))) begin
        ord[j+1] = ord[j];
        j--;
      end
      ord[j+1] = cur;
    end
    for (int i = 0; i < n; i++) begin
      e.data[i*8 +: 8] = data[ord[i]*8 +: 8];
      tmp = ord[i];
      for (int b = 0; b < log2n; b++) e.idx[i*log2n + b] = tmp[b];
    end
    return e;
  endfunction

  function automatic logic [255:0] pk8(input logic [7:0] b[8]);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [159:0] pk3(input int v[8]);
    logic [159:0] r;
    logic [2:0]   t;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      t = 3'(v[i]);
      r[i*3 +: 3] = t;
    end
    return r;
  endfunction

  function automatic logic [255:0] rnd_vec(input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      r[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
    return r;
  endfunction

  function automatic exp_t pick(input int d, input exp_t m);
    return ovr_on[d] ? ovr_e[d] : m;
  endfunction

  // Called at posedge+1; holds in_valid until accepted, returns at posedge+1.
  task automatic send(input int g, input logic [255:0] data, input bit desc);
    bit ok;
    if (g == 0) begin
      pend[0].push_back(pick(0, model(data, desc, 3, 1'b0)));
      pend[1].push_back(pick(1, model(data, desc, 3, 1'b1)));
      ovr_on[0] = 0; ovr_on[1] = 0;
      ab_idat = data[63:0]; ab_desc = desc; ab_iv = 1'b1;
    end else if (g == 2) begin
      pend[2].push_back(model(data, desc, 1, 1'b0));
      c_idat = data[15:0]; c_desc = desc; c_iv = 1'b1;
    end else begin
      pend[3].push_back(model(data, desc, 5, 1'b0));
      d_idat = data; d_desc = desc; d_iv = 1'b1;
    end
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = (g == 0) ? a_irdy : (g == 2) ? c_irdy : d_irdy;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout group=%0d got=no_accept want=accept", g);
    end
    @(posedge clk); #1;
    if (g == 0) ab_iv = 1'b0; else if (g == 2) c_iv = 1'b0; else d_iv = 1'b0;
  endtask

  task automatic drain(input string name);
    bit empty;
    empty = 0;
    for (int t = 0; t < 400 && !empty; t++) begin
      @(negedge clk);
      empty = 1;
      for (int d = 0; d < 4; d++) if (pend[d].size() != 0 || fly[d].size() != 0) empty = 0;
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL drain_%s got=outstanding want=empty", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_ab(input string name);
    chk({name, "_a_valid"}, 256'(a_ov), 256'(0));
    chk({name, "_a_data"}, 256'(a_od), 256'(0));
    chk({name, "_a_idx"}, 256'(a_oi), 256'(0));
    chk({name, "_a_ready"}, 256'(a_irdy), 256'(1));
    chk({name, "_b_valid"}, 256'(b_ov), 256'(0));
    chk({name, "_b_data"}, 256'(b_od), 256'(0));
    chk({name, "_b_ready"}, 256'(b_irdy), 256'(1));
  endtask

  // Monitor: accept stamping, in_ready rule, stall stability, output scoreboard.
  bit           held[4];
  logic [255:0] hold_d[4];
  logic [159:0] hold_i[4];
  exp_t         mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int d = 0; d < 4; d++) held[d] = 0;
      end else begin
        for (int d = 0; d < 4; d++) begin
          chk($sformatf("in_ready_rule_dut%0d", d), 256'(mrdy[d]),
              256'(!(mov[d] && !mordy[d])));
          if (held[d]) begin
            chk($sformatf("stall_valid_dut%0d", d), 256'(mov[d]), 256'(1));
            chk($sformatf("stall_data_dut%0d", d), mod[d], hold_d[d]);
            chk($sformatf("stall_idx_dut%0d", d), 256'(moi[d]), 256'(hold_i[d]));
          end
          if (mv[d] && mrdy[d]) begin
            if (pend[d].size() == 0) begin
              checks++; errors++;
              $display("FAIL accept_unexpected dut%0d got=accept want=none", d);
            end else begin
              mon_e = pend[d].pop_front();
              mon_e.acc = cyc;
              mon_e.st = stall[d];
              fly[d].push_back(mon_e);
            end
          end
          if (mov[d] && mordy[d]) begin
            if (fly[d].size() == 0) begin
              checks++; errors++;
              $display("FAIL stale_output dut%0d got=%0h want=no_output", d, mod[d]);
            end else begin
              mon_e = fly[d].pop_front();
              chk($sformatf("out_data_dut%0d", d), mod[d], mon_e.data);
              if (mon_e.chk_idx) chk($sformatf("out_idx_dut%0d", d), 256'(moi[d]), 256'(mon_e.idx));
              chk($sformatf("latency_dut%0d", d), 256'(cyc - mon_e.acc),
                  256'(lat_s[d] + stall[d] - mon_e.st));
            end
          end
          held[d] = mov[d] && !mordy[d];
          hold_d[d] = mod[d];
          hold_i[d] = moi[d];
          if (!mrdy[d]) stall[d]++;
        end
      end
      cyc++;
    end
  end

  bit done0, done_c, done_d;

  initial begin
    for (int d = 0; d < 4; d++) begin ovr_on[d] = 0; stall[d] = 0; end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_ab("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reverse input, ascending.
    ovr_e[0].data = pk8('{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
    ovr_e[0].idx = pk3('{7, 6, 5, 4, 3, 2, 1, 0});
    ovr_e[0].chk_idx = 1; ovr_on[0] = 1;
    send(0, pk8('{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}), 1'b0);
    // Ties, descending.
    ovr_e[0].data = pk8('{8'd5, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0});
    ovr_e[0].idx = pk3('{6, 0, 2, 4, 5, 1, 7, 3});
    ovr_e[0].chk_idx = 1; ovr_on[0] = 1;
    send(0, pk8('{8'd3, 8'd1, 8'd3, 8'd0, 8'd2, 8'd2, 8'd5, 8'd1}), 1'b1);
    // Signed versus unsigned interpretation of the same keys.
    ovr_e[0].data = pk8('{8'h00, 8'h01, 8'h40, 8'h7F, 8'h80, 8'h81, 8'hC0, 8'hFF});
    ovr_e[0].chk_idx = 0; ovr_on[0] = 1;
    ovr_e[1].data = pk8('{8'h80, 8'h81, 8'hC0, 8'hFF, 8'h00, 8'h01, 8'h40, 8'h7F});
    ovr_e[1].chk_idx = 0; ovr_on[1] = 1;
    send(0, pk8('{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01, 8'h81, 8'h40, 8'hC0}), 1'b0);
    drain("directed");

    // Backpressure: 12 back-to-back vectors, out_ready low on cycles 8-10.
    fork
      for (int v = 0; v < 12; v++) send(0, rnd_vec(8), 1'(v % 2));
      begin
        repeat (8) @(posedge clk);
        #1 ab_ordy = 1'b0;
        repeat (3) @(posedge clk);
        #1 ab_ordy = 1'b1;
      end
    join
    drain("backpressure");

    // Random gaps and random out_ready.
    done0 = 0;
    fork
      begin
        for (int v = 0; v < 30; v++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(0, rnd_vec(8), 1'($urandom_range(0, 1)));
        end
        done0 = 1;
      end
      begin
        while (!done0) begin
          @(posedge clk); #1;
          ab_ordy = ($urandom_range(0, 2) != 0);
        end
        ab_ordy = 1'b1;
      end
    join
    drain("random_ab");

    // Reset with four vectors in flight.
    for (int v = 0; v < 4; v++) send(0, rnd_vec(8), 1'(v % 2));
    #2 rst = 1'b1;
    #1 chk_idle_ab("midreset");
    for (int d = 0; d < 4; d++) begin pend[d].delete(); fly[d].delete(); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(0, rnd_vec(8), 1'b1);
    drain("after_reset");
    repeat (20) @(posedge clk);
    #1;

    // Corner sizes in parallel with random out_ready.
    done_c = 0; done_d = 0;
    fork
      begin
        for (int v = 0; v < 40; v++) send(2, rnd_vec(2), 1'($urandom_range(0, 1)));
        done_c = 1;
      end
      begin
        while (!done_c) begin @(posedge clk); #1; c_ordy = ($urandom_range(0, 2) != 0); end
        c_ordy = 1'b1;
      end
      begin
        for (int v = 0; v < 40; v++) send(3, rnd_vec(32), 1'($urandom_range(0, 1)));
        done_d = 1;
      end
      begin
        while (!done_d) begin @(posedge clk); #1; d_ordy = ($urandom_range(0, 2) != 0); end
        d_ordy = 1'b1;
      end
    join
    drain("corner");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_net_pipe.md
# sort_net_pipe

Parametrised, fully pipelined Batcher odd-even merge sorting network for N = 2^LOG2N lanes of W-bit keys. Adds four things to the fixed-size sorters:
- valid/ready flow control with backpressure;
- a per-vector ascending/descending mode;
- signed or unsigned comparison;
- a per-lane source-index output (argsort).

It sits between a vector producer and consumer in the sort datapath. It accepts one vector per cycle when not stalled.

## Interface
Parameters:
- LOG2N, default 3: log2 of lane count; legal range 1..5; N = 2^LOG2N.
- W, default 32: key width in bits, at least 1.
- SIGNED, default 0: 1 means keys compare as two's complement.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- in_valid, input, 1: input vector present.
- in_ready, output, 1: block can accept the input vector this cycle.
- in_desc, input, 1: sort order; 0 = ascending, 1 = descending. Sampled with the vector.
- in_data, input, N*W: lane i occupies bits [i*W +: W].
- out_valid, output, 1: sorted vector present.
- out_ready, input, 1: consumer accepts the output vector.
- out_data, output, N*W: sorted keys; lane 0 is first in the sort order.
- out_idx, output, N*LOG2N: source lane of each output key; lane i occupies bits [i*LOG2N +: LOG2N].

## Operation
- Network: Batcher odd-even merge sort, S = LOG2N*(LOG2N+1)/2 compare stages, each registered. Lanes with no comparator in a stage pass straight through that stage's register.
- Tags: each key carries its source lane index from entry; the index moves with the key through every compare-exchange.
- Compare-exchange: orders the pair (key, idx) lexicographically.
  - Primary: key, ascending or descending per the vector's mode.
  - Secondary: idx, always ascending, in both modes.
  - Result is a total order. Equal keys leave in increasing source-lane order.
- Mode: in_desc is captured at acceptance and travels down the pipe with the vector. Consecutive vectors may use different modes with no bubble.
- Signedness: SIGNED=0 uses unsigned magnitude compare; SIGNED=1 uses signed compare. The parameter is fixed at elaboration.
- Flow control: one global advance enable, adv = !out_valid || out_ready.
  - in_ready = adv. It is combinational from out_ready and has no path from in_valid.
  - Transfer occurs when in_valid && in_ready.
  - When adv=1, every stage shifts. Each stage's valid bit loads from the stage above; stage 0 loads in_valid.
  - When adv=0, every stage register, including valid bits and mode, holds.
- Bubbles are not compressed: an invalid slot occupies a stage exactly like a vector does.
- Reset: all stage valid bits, keys, indices and mode bits clear to 0 at once. After reset: out_valid=0, out_data=0, out_idx=0, in_ready=1.
- Reset mid-operation discards every in-flight vector. No partial output is produced after reset deasserts.

## Timing
- Latency: a vector accepted at edge k appears on out_data/out_idx with out_valid=1 after edge k+S when there are no stalls. For LOG2N=3, S=6.
- Each stall cycle adds exactly one cycle to the latency of every in-flight vector.
- Throughput: one vector per cycle while out_ready=1.
- While out_valid=1 && out_ready=0, out_data, out_idx and out_valid hold stable.
- Combinational depth per stage: one W+LOG2N-bit compare plus a 2:1 mux.

## Structure
- Shared package sort_pkg:
  - stages(log2n) constant function returning LOG2N*(LOG2N+1)/2;
  - the comparator-pair schedule function (stage, lane) → partner lane and direction.
- Sub-module sort_cmp_xchg, one per comparator. It is purely combinational, with parameters W and SIGNED.
  - Inputs: a/b keys, a/b idx, desc.
  - Outputs: lo/hi key and idx.
- The top level uses generate loops over stage and lane, with a register bank per stage for key, idx, mode and valid.

## Test plan
- Reverse input (N=8, W=8, ascending): lanes 0..7 = 7,6,5,4,3,2,1,0, accepted at edge 0.
  - Required at edge 6: out_data lanes 0..7 = 0..7; out_idx = 7,6,5,4,3,2,1,0.
- Ties, descending: lanes = 3,1,3,0,2,2,5,1 with in_desc=1.
  - Required: out_data = 5,3,3,2,2,1,1,0; out_idx = 6,0,2,4,5,1,7,3.
- Signed (SIGNED=1, W=8, ascending): lanes = 0x7F,0x80,0x00,0xFF,0x01,0x81,0x40,0xC0.
  - Required: out_data = 0x80,0x81,0xC0,0xFF,0x00,0x01,0x40,0x7F.
  - Rerun with SIGNED=0 → 0x00,0x01,0x40,0x7F,0x80,0x81,0xC0,0xFF.
- Backpressure: 12 random vectors back-to-back with alternating in_desc; out_ready=0 on cycles 8-10.
  - in_ready=0 exactly while out_valid && !out_ready.
  - All 12 outputs delivered in order, each correctly sorted in its own mode, with no duplication or loss.
  - out_data stays stable during the stall.
- Reset mid-stream: assert rst asynchronously, mid-cycle, with 4 vectors in flight.
  - out_valid drops immediately; outputs read 0; in_ready=1.
  - After release, a new vector emerges exactly S cycles after acceptance and no stale vector ever appears.
- Corner sizes: LOG2N=1 (S=1) and LOG2N=5 (S=15) with random data and random out_ready.
  - A scoreboard confirms sorted order, tie rule, index permutation and latency.
